// File: rtl/voq_dequeue_engine.sv
// VOQ dequeue engine: pops one descriptor per scheduler grant, streams the packet from the
// packet buffer to the crossbar, then releases its segments and reports queueing latency.
module voq_dequeue_engine #(
  parameter int unsigned EGRESS_CNT = 4,
  parameter int unsigned SEG_WORDS  = 16,
  parameter int unsigned ADDR_W     = 10 + $clog2(SEG_WORDS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sched_valid,
  input  logic [$clog2(EGRESS_CNT)-1:0] sched_sel,
  output logic                          sched_ready,
  input  logic [EGRESS_CNT-1:0]         voq_is_empty,
  output logic                          voq_dequeue_en,
  output logic [$clog2(EGRESS_CNT)-1:0] voq_dequeue_sel,
  input  logic [31:0]                   meta_in,
  input  logic [10:0]                   time_stamp,
  output logic                          pkt_rd_en,
  output logic [ADDR_W-1:0]             pkt_rd_addr,
  input  logic [31:0]                   pkt_rd_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [31:0]                   out_data,
  output logic                          out_sop,
  output logic                          out_eop,
  output logic [3:0]                    out_keep,
  output logic [$clog2(EGRESS_CNT)-1:0] out_egress,
  output logic                          free_en,
  output logic [9:0]                    free_addr,
  output logic                          lat_valid,
  output logic [10:0]                   lat_cycles
);

  localparam int unsigned SelW     = $clog2(EGRESS_CNT);
  localparam int unsigned SegShift = $clog2(SEG_WORDS);

  typedef enum logic [2:0] {StIdle, StDeq, StMeta, StStream, StDrain, StFree} state_e;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [3:0]  keep;
  } beat_t;

  state_e            state_q;
  logic              sched_ready_q;
  logic              deq_en_q;
  logic              free_en_q;
  logic              lat_valid_q;
  logic [SelW-1:0]   sel_q;
  logic [9:0]        seg_addr_q;
  logic [9:0]        free_addr_q;
  logic [1:0]        len_lo_q;
  logic [9:0]        words_q;
  logic [9:0]        rd_idx_q;
  logic [9:0]        push_idx_q;
  logic [10:0]       lat_q;
  logic              inflight_q;
  beat_t             fifo_q [2];
  logic [1:0]        cnt_q;

  logic              pop;
  logic              push;
  logic              rd_issue;
  logic [2:0]        occ;
  logic [3:0]        last_keep;
  beat_t             push_beat;
  logic [ADDR_W-1:0] base;
  logic [11:0]       len_round;

  always_comb begin
    pop  = (cnt_q != 2'd0) && out_ready;
    push = inflight_q;
    // Counting this cycle's pop keeps one read per cycle flowing under continuous ready.
    occ      = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_issue = (state_q == StStream) && (occ < 3'd2);

    last_keep = 4'b1111;
    case (len_lo_q)
      2'd1:    last_keep = 4'b0001;
      2'd2:    last_keep = 4'b0011;
      2'd3:    last_keep = 4'b0111;
      default: last_keep = 4'b1111;
    endcase

    push_beat.data = pkt_rd_data;
    push_beat.sop  = (push_idx_q == 10'd0);
    push_beat.eop  = (push_idx_q == words_q - 10'd1);
    push_beat.keep = push_beat.eop ? last_keep : 4'b1111;

    base      = ADDR_W'(seg_addr_q) << SegShift;
    len_round = {1'b0, meta_in[10:0]} + 12'd3;
  end

  assign sched_ready     = sched_ready_q;
  assign voq_dequeue_en  = deq_en_q;
  assign voq_dequeue_sel = sel_q;
  assign pkt_rd_en       = rd_issue;
  assign pkt_rd_addr     = base + ADDR_W'(rd_idx_q);
  assign out_valid       = (cnt_q != 2'd0);
  assign out_data        = fifo_q[0].data;
  assign out_sop         = fifo_q[0].sop;
  assign out_eop         = fifo_q[0].eop;
  assign out_keep        = fifo_q[0].keep;
  assign out_egress      = sel_q;
  assign free_en         = free_en_q;
  assign free_addr       = free_addr_q;
  assign lat_valid       = lat_valid_q;
  assign lat_cycles      = lat_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      sched_ready_q <= 1'b0;
      deq_en_q      <= 1'b0;
      free_en_q     <= 1'b0;
      lat_valid_q   <= 1'b0;
      sel_q         <= '0;
      seg_addr_q    <= '0;
      free_addr_q   <= '0;
      len_lo_q      <= '0;
      words_q       <= '0;
      rd_idx_q      <= '0;
      lat_q         <= '0;
    end else begin
      deq_en_q    <= 1'b0;
      free_en_q   <= 1'b0;
      lat_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          sched_ready_q <= 1'b1;
          // A grant to an empty VOQ is consumed here without any strobe.
          if (sched_ready_q && sched_valid && !voq_is_empty[sched_sel]) begin
            sel_q         <= sched_sel;
            deq_en_q      <= 1'b1;
            sched_ready_q <= 1'b0;
            state_q       <= StDeq;
          end
        end
        StDeq: state_q <= StMeta;
        StMeta: begin
          seg_addr_q  <= meta_in[31:22];
          len_lo_q    <= meta_in[1:0];
          words_q     <= len_round[11:2];
          rd_idx_q    <= '0;
          lat_valid_q <= 1'b1;
          lat_q       <= time_stamp - meta_in[21:11];
          if (meta_in[10:0] == 11'd0) begin
            free_en_q   <= 1'b1;
            free_addr_q <= meta_in[31:22];
            state_q     <= StFree;
          end else begin
            state_q <= StStream;
          end
        end
        StStream: begin
          if (rd_issue) begin
            rd_idx_q <= rd_idx_q + 10'd1;
            if (rd_idx_q == words_q - 10'd1) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (cnt_q == 2'd0 && !inflight_q) begin
            free_en_q   <= 1'b1;
            free_addr_q <= seg_addr_q;
            state_q     <= StFree;
          end
        end
        StFree: begin
          sched_ready_q <= 1'b1;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Two-entry shift FIFO; entry 0 is always the head presented on out_*.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_q <= 1'b0;
      push_idx_q <= '0;
      cnt_q      <= '0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
    end else begin
      inflight_q <= rd_issue;
      if (state_q == StMeta) begin
        push_idx_q <= '0;
      end else if (push) begin
        push_idx_q <= push_idx_q + 10'd1;
      end
      if (push && !pop) begin
        if (cnt_q == 2'd0) begin
          fifo_q[0] <= push_beat;
        end else begin
          fifo_q[1] <= push_beat;
        end
        cnt_q <= cnt_q + 2'd1;
      end else if (!push && pop) begin
        fifo_q[0] <= fifo_q[1];
        cnt_q     <= cnt_q - 2'd1;
      end else if (push && pop) begin
        if (cnt_q == 2'd1) begin
          fifo_q[0] <= push_beat;
        end else begin
          fifo_q[0] <= fifo_q[1];
          fifo_q[1] <= push_beat;
        end
      end
    end
  end

endmodule

// File: tb/tb_voq_dequeue_engine.sv
// Bench for voq_dequeue_engine: directed and random packets against a per-packet
// reference model of beats, reads, latency and segment release.
module tb_voq_dequeue_engine;

  localparam int unsigned EgressCnt = 4;
  localparam int unsigned SegWords  = 16;
  localparam int unsigned AddrW     = 14;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [3:0]  keep;
    logic [1:0]  eg;
  } tb_beat_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             sched_valid = 1'b0;
  logic [1:0]       sched_sel = '0;
  logic             sched_ready;
  logic [3:0]       voq_is_empty = '1;
  logic             voq_dequeue_en;
  logic [1:0]       voq_dequeue_sel;
  logic [31:0]      meta_in = '0;
  logic [10:0]      time_stamp = '0;
  logic             pkt_rd_en;
  logic [AddrW-1:0] pkt_rd_addr;
  logic [31:0]      pkt_rd_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_data;
  logic             out_sop;
  logic             out_eop;
  logic [3:0]       out_keep;
  logic [1:0]       out_egress;
  logic             free_en;
  logic [9:0]       free_addr;
  logic             lat_valid;
  logic [10:0]      lat_cycles;

  voq_dequeue_engine #(
    .EGRESS_CNT(EgressCnt),
    .SEG_WORDS (SegWords),
    .ADDR_W    (AddrW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .sched_valid    (sched_valid),
    .sched_sel      (sched_sel),
    .sched_ready    (sched_ready),
    .voq_is_empty   (voq_is_empty),
    .voq_dequeue_en (voq_dequeue_en),
    .voq_dequeue_sel(voq_dequeue_sel),
    .meta_in        (meta_in),
    .time_stamp     (time_stamp),
    .pkt_rd_en      (pkt_rd_en),
    .pkt_rd_addr    (pkt_rd_addr),
    .pkt_rd_data    (pkt_rd_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_sop        (out_sop),
    .out_eop        (out_eop),
    .out_keep       (out_keep),
    .out_egress     (out_egress),
    .free_en        (free_en),
    .free_addr      (free_addr),
    .lat_valid      (lat_valid),
    .lat_cycles     (lat_cycles)
  );

  always #5 clk = ~clk;

  logic [31:0] pbuf [0:(1<<AddrW)-1];

  // Packet buffer: answers one cycle after a read, garbage otherwise.
  always @(posedge clk) begin
    if (pkt_rd_en) pkt_rd_data <= pbuf[pkt_rd_addr];
    else           pkt_rd_data <= $urandom;
  end

  int rmode = 0;  // 0: always ready, 1: toggle, 2: random
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rmode == 0)      out_ready = 1'b1;
      else if (rmode == 1) out_ready = ~out_ready;
      else                 out_ready = 1'($urandom_range(0, 1));
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor state
  int               deq_cnt, lat_cnt, free_cnt, issued, popped, max_out, stall_err;
  logic [1:0]       deq_sel;
  logic [10:0]      lat_val;
  logic [9:0]       free_val;
  logic [AddrW-1:0] rd_q[$];
  tb_beat_t         beats[$];
  logic             held_valid = 1'b0;
  tb_beat_t         held;

  task automatic clear_mon();
    deq_cnt = 0; lat_cnt = 0; free_cnt = 0; issued = 0; popped = 0; max_out = 0;
    stall_err = 0;
    rd_q.delete();
    beats.delete();
  endtask

  always @(negedge clk) begin
    tb_beat_t cur;
    cur = {out_data, out_sop, out_eop, out_keep, out_egress};
    if (reset) begin
      if (held_valid && (!out_valid || cur !== held)) stall_err++;
      held_valid = out_valid && !out_ready;
      held = cur;
      if (voq_dequeue_en) begin deq_cnt++; deq_sel = voq_dequeue_sel; end
      if (pkt_rd_en) begin rd_q.push_back(pkt_rd_addr); issued++; end
      if (out_valid && out_ready) begin beats.push_back(cur); popped++; end
      if (lat_valid) begin lat_cnt++; lat_val = lat_cycles; end
      if (free_en) begin free_cnt++; free_val = free_addr; end
      if (issued - popped > max_out) max_out = issued - popped;
    end else begin
      held_valid = 1'b0;
    end
  end

  task automatic start_pkt(input int sel, input int addr, input int ts_enq, input int len,
                           input int now, input bit empty, input int rm);
    clear_mon();
    rmode = rm;
    voq_is_empty = 4'($urandom);
    voq_is_empty[sel] = empty;
    meta_in = {10'(addr), 11'(ts_enq), 11'(len)};
    time_stamp = 11'(now);
    for (int i = 0; i < 100 && !sched_ready; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("sched_ready_before_grant", 64'(sched_ready), 64'd1);
    sched_sel = 2'(sel);
    sched_valid = 1'b1;
    @(posedge clk);
    #1;
    sched_valid = 1'b0;
    sched_sel = 2'($urandom);
  endtask

  task automatic finish_pkt(input int sel, input int addr, input int ts_enq, input int len,
                            input int now, input bit empty);
    int       words, base, r;
    tb_beat_t exp;
    logic [10:0] lat_exp;
    if (empty) begin
      repeat (8) begin @(posedge clk); #1; end
      check_eq("empty_deq_cnt", 64'(deq_cnt), 64'd0);
      check_eq("empty_free_cnt", 64'(free_cnt), 64'd0);
      check_eq("empty_beats", 64'(beats.size()), 64'd0);
      check_eq("empty_sched_ready", 64'(sched_ready), 64'd1);
      return;
    end
    words = (len + 3) / 4;
    base = addr * SegWords;
    r = len % 4;
    lat_exp = 11'(now - ts_enq);
    for (int i = 0; i < 4000 && free_cnt == 0; i++) begin
      @(posedge clk);
      #1;
    end
    repeat (2) begin @(posedge clk); #1; end
    check_eq("deq_cnt", 64'(deq_cnt), 64'd1);
    check_eq("deq_sel", 64'(deq_sel), 64'(sel));
    check_eq("lat_cnt", 64'(lat_cnt), 64'd1);
    check_eq("lat_cycles", 64'(lat_val), 64'(lat_exp));
    check_eq("free_cnt", 64'(free_cnt), 64'd1);
    check_eq("free_addr", 64'(free_val), 64'(addr));
    check_eq("beat_count", 64'(beats.size()), 64'(words));
    check_eq("read_count", 64'(rd_q.size()), 64'(words));
    check_eq("stall_stability", 64'(stall_err), 64'd0);
    check_eq("outstanding_over_2", 64'(max_out > 2), 64'd0);
    check_eq("idle_after_pkt", 64'(sched_ready), 64'd1);
    for (int i = 0; i < rd_q.size() && i < words; i++)
      check_eq($sformatf("rd_addr[%0d]", i), 64'(rd_q[i]), 64'(base + i));
    for (int i = 0; i < beats.size() && i < words; i++) begin
      exp.data = pbuf[base + i];
      exp.sop  = (i == 0);
      exp.eop  = (i == words - 1);
      exp.keep = (exp.eop && r != 0) ? (4'hF >> (4 - r)) : 4'hF;
      exp.eg   = 2'(sel);
      check_eq($sformatf("beat[%0d]", i), 64'(beats[i]), 64'(exp));
    end
  endtask

  task automatic run_pkt(input int sel, input int addr, input int ts_enq, input int len,
                         input int now, input bit empty, input int rm);
    start_pkt(sel, addr, ts_enq, len, now, empty, rm);
    finish_pkt(sel, addr, ts_enq, len, now, empty);
  endtask

  initial begin
    for (int i = 0; i < (1 << AddrW); i++) pbuf[i] = $urandom;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs_zero",
             64'(|{sched_ready, voq_dequeue_en, pkt_rd_en, out_valid, out_sop, out_eop,
                   out_keep, free_en, lat_valid, free_addr, lat_cycles, out_data, out_egress,
                   voq_dequeue_sel, pkt_rd_addr}), 64'd0);
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check_eq("ready_after_reset", 64'(sched_ready), 64'd1);

    // Directed cases
    run_pkt(2, 5, 100, 10, 130, 1'b0, 0);
    run_pkt(1, 40, 7, 64, 300, 1'b0, 1);
    run_pkt(3, 9, 0, 12, 0, 1'b1, 0);
    run_pkt(0, 77, 2040, 0, 5, 1'b0, 0);
    run_pkt(1, 3, 10, 4, 20, 1'b0, 2);
    run_pkt(2, 4, 10, 1, 21, 1'b0, 0);

    // Reset in the middle of an 8-beat packet
    start_pkt(0, 20, 50, 32, 60, 1'b0, 0);
    for (int i = 0; i < 200 && beats.size() < 3; i++) begin
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b0;
    #1;
    check_eq("abort_beats_before", 64'(beats.size()), 64'd3);
    check_eq("abort_out_valid", 64'(out_valid), 64'd0);
    check_eq("abort_out_eop", 64'(out_eop), 64'd0);
    check_eq("abort_free_en", 64'(free_en), 64'd0);
    check_eq("abort_outputs_zero",
             64'(|{sched_ready, voq_dequeue_en, pkt_rd_en, out_valid, out_sop, out_eop,
                   out_keep, free_en, lat_valid, out_data}), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check_eq("abort_no_free", 64'(free_cnt), 64'd0);
    check_eq("abort_no_more_beats", 64'(beats.size()), 64'd3);
    run_pkt(1, 12, 200, 23, 260, 1'b0, 0);

    // Random traffic
    for (int n = 0; n < 30; n++) begin
      int sel, addr, len;
      sel  = $urandom_range(0, EgressCnt - 1);
      addr = $urandom_range(0, 991);
      len  = ($urandom_range(0, 9) < 2) ? $urandom_range(0, 700) : $urandom_range(0, 40);
      run_pkt(sel, addr, $urandom_range(0, 2047), len, $urandom_range(0, 2047),
              ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/voq_dequeue_engine.md
Name: voq_dequeue_engine

Overview:
- Egress-side consumer of the per-ingress VOQ unit.
- On a scheduler grant, pops one packet descriptor from the selected VOQ and captures the returned 32-bit metadata.
- Streams the packet's 32-bit words from the packet buffer to the crossbar over a valid/ready interface, then returns the packet's first segment address to the segment allocator and reports queueing latency.

Parameters:
EGRESS_CNT, 4, number of VOQs/egress ports; sel width = $clog2(EGRESS_CNT)
SEG_WORDS, 16, 32-bit words per packet-buffer segment (power of 2)
ADDR_W, 14, packet-buffer word address width = 10 + $clog2(SEG_WORDS)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
sched_valid  in  1  grant request from scheduler
sched_sel  in  $clog2(EGRESS_CNT)  granted VOQ
sched_ready  out  1  engine idle, grant accepted this cycle
voq_is_empty  in  EGRESS_CNT  VOQ empty flags
voq_dequeue_en  out  1  one-cycle pop strobe to VOQ unit
voq_dequeue_sel  out  $clog2(EGRESS_CNT)  VOQ to pop
meta_in  in  32  descriptor, valid the cycle after voq_dequeue_en: [31:22] first seg addr, [21:11] enqueue timestamp, [10:0] length in bytes
time_stamp  in  11  free-running timestamp
pkt_rd_en  out  1  packet-buffer read strobe
pkt_rd_addr  out  ADDR_W  word address
pkt_rd_data  in  32  read data, valid exactly 1 cycle after pkt_rd_en
out_valid/out_ready  out/in  1/1  crossbar handshake
out_data  out  32  word
out_sop, out_eop  out  1,1  first/last word of packet
out_keep  out  4  byte-valid mask, bit i = byte i
out_egress  out  $clog2(EGRESS_CNT)  destination egress
free_en  out  1  one-cycle strobe releasing segments
free_addr  out  10  first seg addr being released
lat_valid  out  1  one-cycle strobe
lat_cycles  out  11  (time_stamp - enqueue timestamp) mod 2048

Behaviour:
- Reset (async assert, sync deassert): state IDLE. All outputs 0, internal FIFO flushed, in-flight read discarded. No free is issued for an aborted packet; the allocator is reset together with this block.
- FSM states: IDLE, DEQ, META, STREAM, DRAIN, FREE.
- IDLE: sched_ready=1.
  - sched_valid && !voq_is_empty[sched_sel]: latch sel, go to DEQ.
  - sched_valid with an empty VOQ: grant consumed, stays IDLE, no strobes.
- DEQ: voq_dequeue_en=1 and voq_dequeue_sel=latched sel for exactly one cycle, then META.
- META: capture meta_in.
  - words = (len+3)>>2; base = addr<<$clog2(SEG_WORDS).
  - Next cycle: lat_valid=1 for one cycle with lat_cycles = time_stamp - meta[21:11], 11-bit wrap.
  - len==0: go directly to FREE, no output beats. Otherwise go to STREAM.
- STREAM:
  - Issue reads at base, base+1, ... while (FIFO occupancy + in-flight reads) < 2. This sustains 1 word/cycle under continuous out_ready.
  - Returned data is pushed into a 2-entry output FIFO that drives out_*.
  - After the last read is issued, go to DRAIN.
- Beat tagging:
  - sop on beat 0; eop on beat words-1.
  - out_keep = 4'b1111, except on the eop beat: len%4 = 1/2/3 gives 0001/0011/0111 (0 gives 1111).
  - out_egress = latched sel on every beat.
- Output stability: while out_valid && !out_ready, all out_* hold stable and no FIFO overflow occurs.
- DRAIN: wait until the FIFO is empty and no read is in flight, then FREE.
- FREE: free_en=1, free_addr=meta[31:22] for one cycle, then IDLE.
- Same-packet word addressing does not wrap; base+words-1 ≤ 2^ADDR_W-1 is guaranteed upstream.
- Minimum occupancy per packet: DEQ+META+words+DRAIN+FREE. Back-to-back grants are accepted only in IDLE.

Test Plan:
- Reset asserted mid-STREAM (3 of 8 beats sent) -> outputs 0 immediately (async), no eop, no free_en; post-reset grant on VOQ 1 runs normally.
- VOQ 2 non-empty, meta={addr 5, ts 100, len 10}, time_stamp=130 at lat cycle, out_ready=1 -> dequeue_en pulse with sel 2; reads at 80,81,82; 3 beats, sop on beat 0, eop on beat 2, keep 0011; lat_cycles=30; free_en with free_addr=5.
- len=64, out_ready toggling 1/0 every cycle -> 16 beats, data in address order, no drop/duplicate, never more than 2 reads outstanding+buffered.
- Grant with voq_is_empty[sel]=1 -> no voq_dequeue_en, no free_en, sched_ready stays 1.
- ts=2040, time_stamp=5 -> lat_cycles=13 (wrap); len=0 -> zero beats, free_en still pulses.
- len=4 and len=1 -> single beat with sop=eop=1, keep 1111 and 0001 respectively.
